// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
//   block          : one memory word / data-bus beat (16 bits)
//   reg_addr_t     : destination register index carried as a load tag
//   dmem_state_t   : responder FSM state
//   DMEM_RST_VALUE : reset value of memory words and response data
package dmem_responder_pkg;

  typedef logic [15:0] block;
  typedef logic [3:0]  reg_addr_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam block DMEM_RST_VALUE = '0;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x block storage: one synchronous write port, one combinational read port,
// asynchronous clear of every word on reset.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   we          : write enable (commits on posedge)
//   waddr/wdata : write address and data
//   raddr/rdata : combinational read address and data
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  block mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= DMEM_RST_VALUE;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder between the Memory stage and write-back.
// Stores commit at their accept edge with no response; loads return data and tag on
// the rsp channel LATENCY cycles after accept, with a single read outstanding.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   flush                          : branch taken, cancels any in-flight read
//   req_valid/req_ready            : request handshake
//   req_write/req_addr/req_wdata   : store flag, word address, store data
//   req_tag                        : load destination register, echoed as rsp_tag
//   rsp_valid/rsp_ready            : read-response handshake
//   rsp_data/rsp_tag               : read data and echoed tag
//   err_oob                        : sticky, an out-of-range access was accepted
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [3:0]  req_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_tag,
  output logic        err_oob
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  block          data_q, data_d;
  reg_addr_t     tag_q, tag_d;
  logic          err_q, err_d;

  logic [AW-1:0] idx;
  logic          oob;
  logic          accept;
  logic          mem_we;
  block          rd_data;

  assign idx       = req_addr[AW-1:0];
  assign oob       = 32'(req_addr) >= DEPTH;
  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  // Out-of-range stores are accepted but must not alias onto a low index.
  assign mem_we    = accept && req_write && !oob;

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (idx),
    .wdata (req_wdata),
    .raddr (idx),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tag_d   = tag_q;
    err_d   = err_q | (accept && oob);
    unique case (state_q)
      IDLE: begin
        if (accept && !req_write) begin
          data_d = oob ? DMEM_RST_VALUE : rd_data;
          tag_d  = req_tag;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          data_d  = DMEM_RST_VALUE;
          tag_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        // Flush drops the response even when rsp_ready is high this edge.
        if (flush || rsp_ready) begin
          state_d = IDLE;
          data_d  = DMEM_RST_VALUE;
          tag_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= DMEM_RST_VALUE;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_tag   = tag_q;
  assign err_oob   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        err_oob;

  // Index 0: LATENCY=1 instance, index 1: LATENCY=4 instance.
  logic [1:0]       b_req_valid = '0;
  logic [1:0]       b_req_ready;
  logic [1:0]       b_req_write = '0;
  logic [1:0][15:0] b_req_addr = '0;
  logic [1:0][15:0] b_req_wdata = '0;
  logic [1:0][3:0]  b_req_tag = '0;
  logic [1:0]       b_rsp_valid;
  logic [1:0][15:0] b_rsp_data;
  logic [1:0][3:0]  b_rsp_tag;
  logic [1:0]       b_err_oob;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .err_oob(err_oob)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .flush(1'b0), .req_valid(b_req_valid[0]),
    .req_ready(b_req_ready[0]), .req_write(b_req_write[0]), .req_addr(b_req_addr[0]),
    .req_wdata(b_req_wdata[0]), .req_tag(b_req_tag[0]), .rsp_valid(b_rsp_valid[0]),
    .rsp_ready(1'b1), .rsp_data(b_rsp_data[0]), .rsp_tag(b_rsp_tag[0]),
    .err_oob(b_err_oob[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst), .flush(1'b0), .req_valid(b_req_valid[1]),
    .req_ready(b_req_ready[1]), .req_write(b_req_write[1]), .req_addr(b_req_addr[1]),
    .req_wdata(b_req_wdata[1]), .req_tag(b_req_tag[1]), .rsp_valid(b_rsp_valid[1]),
    .rsp_ready(1'b1), .rsp_data(b_rsp_data[1]), .rsp_tag(b_rsp_tag[1]),
    .err_oob(b_err_oob[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a response completes at the next posedge when valid && ready && !flush.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data %0h tag %0h, required no response",
                 rsp_data, rsp_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // All tasks start and end at posedge+1.
  task automatic wait_ready(input string nm);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 32'(req_ready), 32'd1);
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [15:0] data);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    wait_ready("store_ready");
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic issue_load(input logic [15:0] addr, input logic [3:0] tag,
                            input bit push, input logic [15:0] exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_tag = tag;
    wait_ready("load_ready");
    if (push) sb.push_back('{data: exp, tag: tag});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is first seen; lat counts edges from accept.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("req_ready_busy", 32'(req_ready), 32'd0);
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic do_load(input logic [15:0] addr, input logic [3:0] tag,
                         input logic [15:0] exp);
    int lat;
    issue_load(addr, tag, 1'b1, exp);
    wait_rsp(lat);
    chk("load_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
  endtask

  task automatic lat_run(input int k, input int exp_lat);
    int lat = 0;
    b_req_valid[k] = 1'b1; b_req_write[k] = 1'b1; b_req_addr[k] = 16'd3;
    b_req_wdata[k] = 16'h0A0 + 16'(k);
    @(posedge clk); #1;
    b_req_write[k] = 1'b0; b_req_tag[k] = 4'd9;
    @(posedge clk); #1;
    b_req_valid[k] = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!b_rsp_valid[k] && lat < 20);
    chk("param_latency", 32'(lat), 32'(exp_lat));
    chk("param_data", 32'(b_rsp_data[k]), 32'h0A0 + 32'(k));
    chk("param_tag", 32'(b_rsp_tag[k]), 32'd9);
    @(posedge clk); #1;
  endtask

  initial begin
    int  lat;
    bit  any;

    // 1. Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err_oob", 32'(err_oob), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    do_load(16'd5, 4'd2, 16'h0000);

    // 2. Store then load in the next cycle
    do_store(16'd0, 16'h7530);
    do_load(16'd0, 4'd3, 16'h7530);

    // 3. Back-pressure
    do_store(16'd1, 16'd10);
    rsp_ready = 1'b0;
    issue_load(16'd1, 4'd5, 1'b1, 16'd10);
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    chk("bp_data0", 32'(rsp_data), 32'd10);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_data_stable", 32'(rsp_data), 32'd10);
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_req_ready_after", 32'(req_ready), 32'd1);
    chk("bp_valid_after", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // 4a. Flush in WAIT
    issue_load(16'd0, 4'd7, 1'b0, 16'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) any = 1'b1;
    end
    chk("flush_wait_no_rsp", 32'(any), 32'd0);
    @(posedge clk); #1;

    // 4b. Flush in RESP with rsp_ready high
    rsp_ready = 1'b0;
    issue_load(16'd0, 4'd8, 1'b0, 16'h0);
    wait_rsp(lat);
    chk("flush_resp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    any = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) any = 1'b1;
    end
    chk("flush_resp_dropped", 32'(any), 32'd0);
    chk("flush_resp_tag_clr", 32'(rsp_tag), 32'd0);
    @(posedge clk); #1;

    // 4c. Store presented under flush is not written
    do_store(16'd2, 16'h1111);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd2; req_wdata = 16'hBEEF;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; flush = 1'b0;
    do_load(16'd2, 4'd4, 16'h1111);

    // 5. Out-of-range
    do_store(16'd64, 16'h1234);
    @(negedge clk);
    chk("oob_err_set", 32'(err_oob), 32'd1);
    @(posedge clk); #1;
    do_load(16'd64, 4'd6, 16'h0000);
    do_load(16'd0, 4'd1, 16'h7530);
    @(negedge clk);
    chk("oob_err_sticky", 32'(err_oob), 32'd1);
    @(posedge clk); #1;

    // 6. Back-to-back stores
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 16'(8 + i); req_wdata = 16'(16'h0100 + i);
      @(negedge clk);
      chk("b2b_accept", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_load(16'(8 + i), 4'(i), 16'(16'h0100 + i));
    end

    // Reset mid-read clears state and memory
    issue_load(16'd0, 4'd2, 1'b0, 16'h0);
    rst = 1'b0;
    #2;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_err", 32'(err_oob), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_load(16'd0, 4'd2, 16'h0000);

    // LATENCY=1 and LATENCY=4 instances
    lat_run(0, 1);
    lat_run(1, 4);

    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
